// File: rtl/ahb_dual_master_arbiter.sv
// Two-master AHB-Lite arbiter in front of a single slave port. A master that
// loses arbitration has its address phase parked in a one-entry buffer and is
// stalled through its own hready until that transfer has been issued and completed.
module ahb_dual_master_arbiter #(
  parameter int FIXED_PRIORITY = 0,
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic [ADDR_W-1:0] m0_haddr,
  input  logic [1:0]        m0_htrans,
  input  logic [1:0]        m0_hsize,
  input  logic              m0_hwrite,
  input  logic [DATA_W-1:0] m0_hwdata,
  output logic              m0_hready,
  output logic [DATA_W-1:0] m0_hrdata,
  output logic              m0_hresp,
  input  logic [ADDR_W-1:0] m1_haddr,
  input  logic [1:0]        m1_htrans,
  input  logic [1:0]        m1_hsize,
  input  logic              m1_hwrite,
  input  logic [DATA_W-1:0] m1_hwdata,
  output logic              m1_hready,
  output logic [DATA_W-1:0] m1_hrdata,
  output logic              m1_hresp,
  output logic [ADDR_W-1:0] s_haddr,
  output logic [1:0]        s_htrans,
  output logic [1:0]        s_hsize,
  output logic              s_hwrite,
  output logic              s_hsel,
  output logic [DATA_W-1:0] s_hwdata,
  output logic              s_hready,
  input  logic              s_hreadyout,
  input  logic [DATA_W-1:0] s_hrdata,
  input  logic              s_hresp
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_M0   = 2'd1,
    OWN_M1   = 2'd2
  } owner_e;

  localparam logic [1:0] HTRANS_IDLE = 2'b00;

  owner_e            r_owner, w_owner_nxt;
  logic              r_pend_v0, r_pend_v1, w_pend_v0_nxt, w_pend_v1_nxt;
  logic              r_last_grant, w_last_grant_nxt;  // 0 = M0 granted last, 1 = M1
  logic [ADDR_W-1:0] r_pend_addr0, r_pend_addr1;
  logic [1:0]        r_pend_trans0, r_pend_trans1;
  logic [1:0]        r_pend_size0, r_pend_size1;
  logic              r_pend_write0, r_pend_write1;

  logic w_live0, w_live1, w_cand0, w_cand1;
  logic w_grant0, w_grant1, w_cap0, w_cap1;

  // A pending master stays stalled; the owner sees the slave's ready.
  assign m0_hready = r_pend_v0 ? 1'b0 : (r_owner == OWN_M0) ? s_hreadyout : 1'b1;
  assign m1_hready = r_pend_v1 ? 1'b0 : (r_owner == OWN_M1) ? s_hreadyout : 1'b1;

  // BUSY (01) counts as idle: only htrans[1] marks a real transfer.
  assign w_live0 = nrst & m0_htrans[1] & m0_hready;
  assign w_live1 = nrst & m1_htrans[1] & m1_hready;
  assign w_cand0 = nrst & (r_pend_v0 | w_live0);
  assign w_cand1 = nrst & (r_pend_v1 | w_live1);

  assign s_hready  = s_hreadyout;
  assign m0_hrdata = s_hrdata;
  assign m1_hrdata = s_hrdata;
  assign m0_hresp  = (r_owner == OWN_M0) ? s_hresp : 1'b0;
  assign m1_hresp  = (r_owner == OWN_M1) ? s_hresp : 1'b0;

  always_comb begin
    s_hwdata = '0;
    if (r_owner == OWN_M0)      s_hwdata = m0_hwdata;
    else if (r_owner == OWN_M1) s_hwdata = m1_hwdata;
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    w_owner_nxt      = r_owner;
    w_last_grant_nxt = r_last_grant;
    w_grant0         = 1'b0;
    w_grant1         = 1'b0;
    s_hsel           = 1'b0;
    s_htrans         = HTRANS_IDLE;
    s_haddr          = '0;
    s_hsize          = '0;
    s_hwrite         = 1'b0;

    if (s_hreadyout) begin
      w_grant0 = w_cand0 & (~w_cand1 | (FIXED_PRIORITY != 0) | r_last_grant);
      w_grant1 = w_cand1 & ~w_grant0;
      if (w_grant0) begin
        w_owner_nxt      = OWN_M0;
        w_last_grant_nxt = 1'b0;
        s_hsel           = 1'b1;
        s_haddr          = r_pend_v0 ? r_pend_addr0  : m0_haddr;
        s_htrans         = r_pend_v0 ? r_pend_trans0 : m0_htrans;
        s_hsize          = r_pend_v0 ? r_pend_size0  : m0_hsize;
        s_hwrite         = r_pend_v0 ? r_pend_write0 : m0_hwrite;
      end else if (w_grant1) begin
        w_owner_nxt      = OWN_M1;
        w_last_grant_nxt = 1'b1;
        s_hsel           = 1'b1;
        s_haddr          = r_pend_v1 ? r_pend_addr1  : m1_haddr;
        s_htrans         = r_pend_v1 ? r_pend_trans1 : m1_htrans;
        s_hsize          = r_pend_v1 ? r_pend_size1  : m1_hsize;
        s_hwrite         = r_pend_v1 ? r_pend_write1 : m1_hwrite;
      end else begin
        w_owner_nxt = OWN_NONE;
      end
    end

    // A live request that is not issued this cycle is parked in its buffer.
    w_cap0        = w_live0 & ~w_grant0;
    w_cap1        = w_live1 & ~w_grant1;
    w_pend_v0_nxt = w_grant0 ? 1'b0 : (w_cap0 | r_pend_v0);
    w_pend_v1_nxt = w_grant1 ? 1'b0 : (w_cap1 | r_pend_v1);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the same pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_owner      <= OWN_NONE;
      r_pend_v0    <= 1'b0;
      r_pend_v1    <= 1'b0;
      r_last_grant <= 1'b1;
    end else begin
      r_owner      <= w_owner_nxt;
      r_pend_v0    <= w_pend_v0_nxt;
      r_pend_v1    <= w_pend_v1_nxt;
      r_last_grant <= w_last_grant_nxt;
    end
  end

  // NOTE: buffer payload has no reset; it is only ever read while its pend_v
  // flag is set, and that flag is cleared asynchronously.
  always_ff @(posedge clk) begin
    if (w_cap0) begin
      r_pend_addr0  <= m0_haddr;
      r_pend_trans0 <= m0_htrans;
      r_pend_size0  <= m0_hsize;
      r_pend_write0 <= m0_hwrite;
    end
    if (w_cap1) begin
      r_pend_addr1  <= m1_haddr;
      r_pend_trans1 <= m1_htrans;
      r_pend_size1  <= m1_hsize;
      r_pend_write1 <= m1_hwrite;
    end
  end

endmodule
